// File: rtl/pong_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pong_pkg : shared game state encoding, screen geometry and paddle helper
// Revision  : 1.0
// ---------------------------------------------------------------------------
package pong_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SERVE = 2'd1,
    ST_PLAY  = 2'd2,
    ST_OVER  = 2'd3
  } game_state_t;

  localparam int SCREEN_W     = 640;
  localparam int SCREEN_H     = 480;
  localparam int PADDLE_X_MIN = 40;
  localparam int PADDLE_X_MAX = 80;
  localparam int PADDLE_H     = 80;
  localparam int BALL_SIZE    = 8;
  localparam int WALL_X       = 560;

  localparam int SERVE_X        = 316;
  localparam int SERVE_Y        = 236;
  localparam int PADDLE_Y_RESET = 200;
  localparam int LIVES_INIT     = 3;

  // Limits on the top-left coordinate so the sprite stays fully on screen.
  localparam int PADDLE_Y_MAX = SCREEN_H - PADDLE_H;
  localparam int BALL_Y_MAX   = SCREEN_H - BALL_SIZE;
  localparam int BALL_X_MAX   = WALL_X - BALL_SIZE;

  function automatic logic [9:0] paddle_next(input logic [9:0] y,
                                             input logic       up,
                                             input logic       dn,
                                             input int         step);
    logic [10:0] sum;
    sum         = {1'b0, y} + 11'(step);
    paddle_next = y;
    if (up && !dn) begin
      paddle_next = (y < 10'(step)) ? 10'd0 : y - 10'(step);
    end else if (dn && !up) begin
      paddle_next = (sum > 11'(PADDLE_Y_MAX)) ? 10'(PADDLE_Y_MAX) : sum[9:0];
    end
  endfunction

endpackage
`default_nettype wire

// File: rtl/btn_sync.sv
`default_nettype none
// ---------------------------------------------------------------------------
// btn_sync : two-flop synchroniser for a raw button, optional rising-edge out
// Revision : 1.0
// ---------------------------------------------------------------------------
module btn_sync #(
  parameter bit RISE_EDGE = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic out
);

  logic meta;
  logic sync;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta <= 1'b0;
      sync <= 1'b0;
    end else begin
      meta <= btn;
      sync <= meta;
    end
  end

  generate
    if (RISE_EDGE) begin : g_edge
      logic prev;
      always_ff @(posedge clk or posedge reset) begin
        if (reset) prev <= 1'b0;
        else       prev <= sync;
      end
      assign out = sync & ~prev;
    end else begin : g_level
      assign out = sync;
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/game_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// game_ctrl : single-player pong controller (paddle, ball, lives, score)
//             Define GAME_CTRL_SCORE_EN to build the hit-count score register.
// Revision  : 1.0
// ---------------------------------------------------------------------------
module game_ctrl
  import pong_pkg::*;
#(
  parameter int SERVE_FRAMES = 60,
  parameter int PADDLE_STEP  = 4,
  parameter int BALL_SPEED   = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_start,
  output logic [9:0] player_y_pos,
  output logic [9:0] ball_x,
  output logic [9:0] ball_y,
  output logic [1:0] game_state,
  output logic [1:0] lives,
  output logic [7:0] score,
  output logic       miss
);

  localparam int CNT_W = $clog2(SERVE_FRAMES + 1);

  localparam logic signed [10:0] SPEED     = 11'(BALL_SPEED);
  localparam logic signed [10:0] X_MAX_S   = 11'(BALL_X_MAX);
  localparam logic signed [10:0] Y_MAX_S   = 11'(BALL_Y_MAX);
  localparam logic signed [10:0] PLANE_X_S = 11'(PADDLE_X_MAX);

  logic up_s, down_s, start_rise;

  btn_sync #(.RISE_EDGE(1'b0)) u_sync_up (
    .clk   (clk),
    .reset (reset),
    .btn   (btn_up),
    .out   (up_s)
  );

  btn_sync #(.RISE_EDGE(1'b0)) u_sync_down (
    .clk   (clk),
    .reset (reset),
    .btn   (btn_down),
    .out   (down_s)
  );

  btn_sync #(.RISE_EDGE(1'b1)) u_sync_start (
    .clk   (clk),
    .reset (reset),
    .btn   (btn_start),
    .out   (start_rise)
  );

  game_state_t      state_q, state_d;
  logic [CNT_W-1:0] serve_cnt_q, serve_cnt_d;
  logic [9:0]       paddle_q, paddle_d;
  logic [9:0]       ball_x_q, ball_x_d;
  logic [9:0]       ball_y_q, ball_y_d;
  logic             dx_neg_q, dx_neg_d;
  logic             dy_neg_q, dy_neg_d;
  logic [1:0]       lives_q, lives_d;
  logic             miss_q, miss_d;

  logic signed [10:0] dx, dy, next_x, next_y;
  logic               in_play_tick, at_plane, paddle_hit, miss_evt, serve_done;
  logic               new_game, enter_serve;

  // Ball geometry is evaluated from pre-tick positions for both axes at once.
  always_comb begin
    dx           = dx_neg_q ? -SPEED : SPEED;
    dy           = dy_neg_q ? -SPEED : SPEED;
    next_x       = $signed({1'b0, ball_x_q}) + dx;
    next_y       = $signed({1'b0, ball_y_q}) + dy;
    in_play_tick = frame_tick && (state_q == ST_PLAY);
    at_plane     = dx_neg_q && (next_x <= PLANE_X_S);
    paddle_hit   = (({1'b0, ball_y_q} + 11'(BALL_SIZE)) > {1'b0, paddle_q}) &&
                   ({1'b0, ball_y_q} < ({1'b0, paddle_q} + 11'(PADDLE_H)));
    miss_evt     = in_play_tick && at_plane && !paddle_hit;
    serve_done   = frame_tick && (state_q == ST_SERVE) &&
                   (serve_cnt_q == CNT_W'(SERVE_FRAMES - 1));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start_rise) state_d = ST_SERVE;
      ST_SERVE: if (serve_done) state_d = ST_PLAY;
      ST_PLAY:  if (miss_evt)   state_d = (lives_q > 2'd1) ? ST_SERVE : ST_OVER;
      ST_OVER:  if (start_rise) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  assign new_game    = (state_q == ST_IDLE) && start_rise;
  assign enter_serve = (state_d == ST_SERVE) && (state_q != ST_SERVE);

  always_comb begin
    paddle_d    = paddle_q;
    ball_x_d    = ball_x_q;
    ball_y_d    = ball_y_q;
    dx_neg_d    = dx_neg_q;
    dy_neg_d    = dy_neg_q;
    lives_d     = lives_q;
    serve_cnt_d = serve_cnt_q;
    miss_d      = 1'b0;

    if (frame_tick && ((state_q == ST_SERVE) || (state_q == ST_PLAY))) begin
      paddle_d = paddle_next(paddle_q, up_s, down_s, PADDLE_STEP);
    end

    if (frame_tick && (state_q == ST_SERVE)) begin
      serve_cnt_d = serve_cnt_q + 1'b1;
    end

    if (in_play_tick) begin
      if (miss_evt) begin
        // A missed ball freezes in place; a re-serve below overrides it.
        miss_d  = 1'b1;
        lives_d = (lives_q > 2'd1) ? lives_q - 2'd1 : 2'd0;
      end else begin
        if (at_plane) begin
          ball_x_d = 10'(PADDLE_X_MAX + 1);
          dx_neg_d = 1'b0;
        end else if (next_x > X_MAX_S) begin
          ball_x_d = 10'(BALL_X_MAX);
          dx_neg_d = ~dx_neg_q;
        end else begin
          ball_x_d = next_x[9:0];
        end

        if (next_y < 11'sd0) begin
          ball_y_d = 10'd0;
          dy_neg_d = ~dy_neg_q;
        end else if (next_y > Y_MAX_S) begin
          ball_y_d = 10'(BALL_Y_MAX);
          dy_neg_d = ~dy_neg_q;
        end else begin
          ball_y_d = next_y[9:0];
        end
      end
    end

    if (new_game) begin
      lives_d = 2'(LIVES_INIT);
    end

    if (enter_serve) begin
      ball_x_d    = 10'(SERVE_X);
      ball_y_d    = 10'(SERVE_Y);
      dx_neg_d    = 1'b1;
      dy_neg_d    = 1'b0;
      serve_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      paddle_q    <= 10'(PADDLE_Y_RESET);
      ball_x_q    <= 10'(SERVE_X);
      ball_y_q    <= 10'(SERVE_Y);
      dx_neg_q    <= 1'b1;
      dy_neg_q    <= 1'b0;
      lives_q     <= 2'd0;
      serve_cnt_q <= '0;
      miss_q      <= 1'b0;
    end else begin
      paddle_q    <= paddle_d;
      ball_x_q    <= ball_x_d;
      ball_y_q    <= ball_y_d;
      dx_neg_q    <= dx_neg_d;
      dy_neg_q    <= dy_neg_d;
      lives_q     <= lives_d;
      serve_cnt_q <= serve_cnt_d;
      miss_q      <= miss_d;
    end
  end

`ifdef GAME_CTRL_SCORE_EN
  logic [7:0] score_q;
  logic       hit_evt;

  assign hit_evt = in_play_tick && at_plane && paddle_hit;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      score_q <= 8'd0;
    end else if (new_game) begin
      score_q <= 8'd0;
    end else if (hit_evt && (score_q != 8'hFF)) begin
      score_q <= score_q + 8'd1;
    end
  end

  assign score = score_q;
`else
  assign score = 8'd0;
`endif

  assign player_y_pos = paddle_q;
  assign ball_x       = ball_x_q;
  assign ball_y       = ball_y_q;
  assign game_state   = state_q;
  assign lives        = lives_q;
  assign miss         = miss_q;

endmodule
`default_nettype wire

// File: tb/tb_game_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_game_ctrl : directed scoreboard bench for game_ctrl
// Revision     : 1.0
// ---------------------------------------------------------------------------
module tb_game_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       frame_tick;
  logic       btn_up, btn_down, btn_start;
  logic [9:0] player_y_pos, ball_x, ball_y;
  logic [1:0] game_state, lives;
  logic [7:0] score;
  logic       miss;

  game_ctrl #(
    .SERVE_FRAMES (60),
    .PADDLE_STEP  (4),
    .BALL_SPEED   (2)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .frame_tick   (frame_tick),
    .btn_up       (btn_up),
    .btn_down     (btn_down),
    .btn_start    (btn_start),
    .player_y_pos (player_y_pos),
    .ball_x       (ball_x),
    .ball_y       (ball_y),
    .game_state   (game_state),
    .lives        (lives),
    .score        (score),
    .miss         (miss)
  );

  always #5 clk = ~clk;

`ifdef GAME_CTRL_SCORE_EN
  localparam int HIT_SCORE = 1;
`else
  localparam int HIT_SCORE = 0;
`endif

  localparam int F_ST = 0, F_PAD = 1, F_BX = 2, F_BY = 3, F_LV = 4, F_SC = 5, F_MS = 6;

  string nm_q[$];
  int    fld_q[$];
  int    val_q[$];
  int    checks = 0;
  int    errors = 0;

  function automatic int actual(input int f);
    case (f)
      F_ST:    return int'(game_state);
      F_PAD:   return int'(player_y_pos);
      F_BX:    return int'(ball_x);
      F_BY:    return int'(ball_y);
      F_LV:    return int'(lives);
      F_SC:    return int'(score);
      F_MS:    return int'(miss);
      default: return -1;
    endcase
  endfunction

  function automatic string fname(input int f);
    case (f)
      F_ST:    return "game_state";
      F_PAD:   return "player_y_pos";
      F_BX:    return "ball_x";
      F_BY:    return "ball_y";
      F_LV:    return "lives";
      F_SC:    return "score";
      F_MS:    return "miss";
      default: return "?";
    endcase
  endfunction

  task automatic expect_val(input string nm, input int f, input int v);
    nm_q.push_back(nm);
    fld_q.push_back(f);
    val_q.push_back(v);
  endtask

  // Negative arguments mean "don't care" for that output.
  task automatic expect_out(input string nm, input int st, input int pad, input int bx,
                            input int by, input int lv, input int sc, input int ms);
    if (st  >= 0) expect_val(nm, F_ST,  st);
    if (pad >= 0) expect_val(nm, F_PAD, pad);
    if (bx  >= 0) expect_val(nm, F_BX,  bx);
    if (by  >= 0) expect_val(nm, F_BY,  by);
    if (lv  >= 0) expect_val(nm, F_LV,  lv);
    if (sc  >= 0) expect_val(nm, F_SC,  sc);
    if (ms  >= 0) expect_val(nm, F_MS,  ms);
  endtask

  // Monitor: outputs are stable at the falling edge; drain every pending expectation.
  always @(negedge clk) begin
    string nm;
    int    f, v, a;
    while (val_q.size() != 0) begin
      nm = nm_q.pop_front();
      f  = fld_q.pop_front();
      v  = val_q.pop_front();
      a  = actual(f);
      checks++;
      if (a != v) begin
        errors++;
        $display("FAIL %s %s: got %0d expected %0d", nm, fname(f), a, v);
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
    frame_tick = 1'b1;
    @(posedge clk); #1;
    frame_tick = 1'b0;
  endtask

  task automatic run_ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic set_btns(input logic up, input logic dn);
    btn_up   = up;
    btn_down = dn;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic press_start();
    btn_start = 1'b1;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic release_start();
    btn_start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset      = 1'b1;
    frame_tick = 1'b0;
    btn_up     = 1'b0;
    btn_down   = 1'b0;
    btn_start  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    expect_out("reset", 0, 200, 316, 236, 0, 0, 0);
    @(posedge clk); #1;
    reset = 1'b0;

    set_btns(1'b0, 1'b1);
    tick();
    expect_out("idle_tick", 0, 200, 316, 236, 0, 0, 0);
    set_btns(1'b0, 1'b0);

    press_start();
    expect_out("start", 1, 200, 316, 236, 3, 0, 0);
    release_start();

    // Paddle clamping at the top, then both-pressed hold, then downward motion.
    set_btns(1'b1, 1'b0);
    run_ticks(49);
    expect_out("up49", 1, 4, 316, 236, -1, -1, -1);
    tick(); expect_out("up_clamp1", -1, 0, -1, -1, -1, -1, -1);
    tick(); expect_out("up_clamp2", -1, 0, -1, -1, -1, -1, -1);
    tick(); expect_out("up_clamp3", -1, 0, -1, -1, -1, -1, -1);
    set_btns(1'b1, 1'b1);
    tick(); expect_out("both_hold", 1, 0, -1, -1, -1, -1, -1);
    tick();
    set_btns(1'b0, 1'b1);
    run_ticks(4);
    tick(); expect_out("serve59", 1, 20, 316, 236, 3, -1, -1);
    tick(); expect_out("serve60", 2, 24, 316, 236, 3, -1, 0);

    run_ticks(92);
    tick(); expect_out("down396", 2, 396, 130, 422, -1, -1, -1);
    tick(); expect_out("down400", 2, 400, 128, 424, -1, -1, -1);
    tick(); expect_out("down_hold", 2, 400, 126, 426, -1, -1, -1);

    // Ball reaches the paddle plane at the bottom wall; paddle at 400 hits it.
    run_ticks(21);
    tick(); expect_out("pre_hit", 2, 400, 82, 470, 3, 0, 0);
    tick(); expect_out("hit", 2, 400, 81, 472, 3, HIT_SCORE, 0);
    tick(); expect_out("bottom_wall", 2, -1, 83, 472, -1, -1, -1);
    tick(); expect_out("after_bottom", 2, -1, 85, 470, -1, -1, -1);

    set_btns(1'b1, 1'b0);
    run_ticks(25);
    expect_out("paddle300", 2, 300, 135, 420, -1, -1, -1);
    set_btns(1'b0, 1'b0);

    run_ticks(207);
    tick(); expect_out("pre_right", 2, 300, 551, 4, -1, -1, -1);
    tick(); expect_out("right_wall", 2, 300, 552, 2, -1, -1, -1);
    tick(); expect_out("top_touch", 2, 300, 550, 0, -1, -1, -1);
    tick(); expect_out("top_wall", 2, 300, 548, 0, -1, -1, -1);
    tick(); expect_out("after_top", 2, 300, 546, 2, -1, -1, -1);

    run_ticks(231);
    tick(); expect_out("pre_miss1", 2, 300, 82, 466, 3, -1, 0);
    tick(); expect_out("miss1", 1, 300, 316, 236, 2, HIT_SCORE, 1);
    step(); expect_out("miss1_end", 1, -1, -1, -1, 2, -1, 0);

    run_ticks(59);
    expect_out("reserve59", 1, -1, 316, 236, 2, -1, -1);
    tick(); expect_out("reserve60", 2, -1, 316, 236, 2, -1, -1);
    run_ticks(116);
    tick(); expect_out("pre_miss2", 2, 300, 82, 470, 2, -1, 0);
    tick(); expect_out("miss2", 1, 300, 316, 236, 1, -1, 1);

    run_ticks(60);
    run_ticks(117);
    tick(); expect_out("miss_last", 3, 300, 82, 470, 0, HIT_SCORE, 1);
    step(); expect_out("miss_last_end", 3, -1, -1, -1, 0, -1, 0);

    set_btns(1'b1, 1'b0);
    tick(); expect_out("over_tick", 3, 300, 82, 470, 0, -1, 0);
    set_btns(1'b0, 1'b0);

    press_start();
    expect_out("over_start", 0, -1, -1, -1, 0, HIT_SCORE, 0);
    release_start();
    press_start();
    expect_out("restart", 1, -1, 316, 236, 3, 0, 0);
    release_start();

    run_ticks(60);
    run_ticks(3);
    expect_out("play_again", 2, -1, 310, 242, 3, -1, -1);
    @(posedge clk); #2;
    reset = 1'b1;
    expect_out("async_reset", 0, 200, 316, 236, 0, 0, 0);
    #1;
    checks++;
    if (game_state != 2'd0) begin
      errors++;
      $display("FAIL async_now game_state: got %0d expected 0", game_state);
    end
    checks++;
    if (player_y_pos != 10'd200) begin
      errors++;
      $display("FAIL async_now player_y_pos: got %0d expected 200", player_y_pos);
    end
    checks++;
    if ((ball_x != 10'd316) || (ball_y != 10'd236)) begin
      errors++;
      $display("FAIL async_now ball: got (%0d,%0d) expected (316,236)", ball_x, ball_y);
    end
    checks++;
    if (lives != 2'd0) begin
      errors++;
      $display("FAIL async_now lives: got %0d expected 0", lives);
    end
    checks++;
    if ((score != 8'd0) || (miss != 1'b0)) begin
      errors++;
      $display("FAIL async_now score/miss: got %0d/%0d expected 0/0", score, miss);
    end
    @(negedge clk);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/game_ctrl.md
GAME_CTRL -- requirements
Module: game_ctrl

Interface
REQ-001 Parameter SERVE_FRAMES, default 60, is the number of frame ticks spent in SERVE before PLAY.
REQ-002 Parameter PADDLE_STEP, default 4, is the paddle displacement in pixels per frame tick.
REQ-003 Parameter BALL_SPEED, default 2, is the ball |dx| and |dy| in pixels per frame tick.
REQ-004 Port list SHALL be as follows:
- clk  input  1  single system clock; all state on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- frame_tick  input  1  one-clk pulse at start of vertical blank.
- btn_up, btn_down, btn_start  input  1 each  asynchronous raw buttons, active-high.
- player_y_pos  output  10  paddle top row.
- ball_x, ball_y  output  10 each  ball top-left pixel.
- game_state  output  2  IDLE=0, SERVE=1, PLAY=2, OVER=3.
- lives  output  2  remaining lives.
- score  output  8  paddle hit count.
- miss  output  1  one-clk pulse on a missed ball.

Function
REQ-005 Buttons SHALL pass through a 2-flop synchroniser; the synchronised values are sampled only on frame_tick.
REQ-006 All outputs SHALL be registered and change exactly one clk after the frame_tick (or btn_start) cycle that causes them.
REQ-007 FSM transitions:
- IDLE --start--> SERVE, with lives=3 and score=0.
- SERVE --counter reaches SERVE_FRAMES ticks--> PLAY.
- PLAY --miss with lives>1--> SERVE, lives-1.
- PLAY --miss with lives==1--> OVER, lives=0.
- OVER --start--> IDLE.
- No other transitions.
REQ-008 On entry to SERVE the ball SHALL be at (316,236) with dx=-BALL_SPEED, dy=+BALL_SPEED, and the serve frame counter cleared.
REQ-009 Paddle: in SERVE/PLAY, per tick, up-only subtracts PADDLE_STEP and down-only adds PADDLE_STEP, clamped to 0..400; with both or neither pressed the paddle is held.
REQ-010 Ball update happens only in PLAY, per tick, using signed 11-bit next = pos + d computed from pre-tick paddle and ball values.
REQ-011 If next_y < 0, then y=0 and dy negates; if next_y > 472, then y=472 and dy negates.
REQ-012 Right wall: if next_x > 552, then x=552 and dx negates.
REQ-013 Paddle plane:
- Applies when dx<0 and next_x <= 80.
- Hit if ball_y+8 > player_y_pos and ball_y < player_y_pos+80.
- On hit: x=81, dx negates, score+1 saturating at 255.
- Otherwise: miss pulses for 1 clk and REQ-007 applies; the ball position is not updated.
REQ-014 Simultaneous wall and paddle conditions on one tick SHALL be resolved independently per axis.
REQ-015 frame_tick in IDLE/OVER SHALL move nothing.
REQ-016 btn_start SHALL be edge-detected (rising edge, synchronised) and SHALL act immediately, without waiting for frame_tick.

Reset
REQ-017 Asserting reset SHALL asynchronously force the following, including mid-game:
- game_state=IDLE
- player_y_pos=200
- ball_x=316, ball_y=236
- lives=0, score=0, miss=0
- counters and synchroniser flops cleared

Configuration
REQ-018 With GAME_CTRL_SCORE_EN defined, score SHALL behave per REQ-013; without it, score SHALL be constant 0 and no counter logic is built.

Structure
REQ-019 Package pong_pkg SHALL hold:
- the game_state enum
- screen constants 640/480
- PADDLE_X_MIN=40, PADDLE_X_MAX=80, PADDLE_H=80
- BALL_SIZE=8
- WALL_X=560
- serve coordinates
REQ-020 The synchroniser plus rising-edge detector SHALL be one sub-module, btn_sync, instantiated three times.

Verification
REQ-021 Reset, then btn_start pulse: game_state=SERVE next clk, lives=3; after 60 ticks game_state=PLAY, ball (316,236).
REQ-022 btn_up held from player_y_pos=4 for 3 ticks gives 0, 0, 0; btn_down from 396 gives 400 and stays at 400; both buttons held leaves the paddle unchanged.
REQ-023 PLAY with ball (82,100), dx=-2, player_y_pos=60: next tick x=81, dx=+2, score=1; if undefined GAME_CTRL_SCORE_EN, score stays 0.
REQ-024 PLAY with ball (82,300), player_y_pos=60: miss pulses 1 clk, lives 3->2, game_state=SERVE; from lives=1 the same case gives game_state=OVER.
REQ-025 Ball (551,471), dx=dy=+2: next tick (552,472), dx=-2, dy=-2; reset asserted mid-PLAY returns all outputs to reset values without a clock edge.
